// File: rtl/fitness_pkg.sv
// fitness_pkg: shared activity codes and widths for the fitness tracker
//   ACT_W      - width of the activity code bus
//   SEC_W      - width of the seconds counters consumed downstream
//   activity_e - IDLE=0, RUN=1, WALK=2, CYCLE=3, PAUSED=4
//   is_active  - true for the three states that accumulate time
package fitness_pkg;
    localparam int ACT_W = 3;
    localparam int SEC_W = 8;
    typedef enum logic [ACT_W-1:0] {
        ACT_IDLE   = 3'd0,
        ACT_RUN    = 3'd1,
        ACT_WALK   = 3'd2,
        ACT_CYCLE  = 3'd3,
        ACT_PAUSED = 3'd4
    } activity_e;
    function automatic logic is_active(activity_e a);
        return a == ACT_RUN || a == ACT_WALK || a == ACT_CYCLE;
    endfunction
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes, debounces and edge-detects one raw push-button
//   i_clk    - system clock
//   i_rst_n  - asynchronous active-low reset
//   i_btn    - raw asynchronous button level, active-high
//   o_press  - one-cycle pulse on each accepted 0->1 transition
// Build option: ACTIVITY_DEBOUNCE_EN enables the debouncer; without it the
// synchronized level is taken as the accepted level directly.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);
    logic r_s1;
    logic r_s2;
    logic r_prev;
    logic w_acc;
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
        end
    end
`ifdef ACTIVITY_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_acc;
    // Counts consecutive cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_acc <= 1'b0;
        end else if (r_s2 == r_acc) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt <= '0;
            r_acc <= r_s2;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
    assign w_acc = r_acc;
`else
    assign w_acc = r_s2;
`endif
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_prev <= 1'b0;
        else          r_prev <= w_acc;
    end
    assign o_press = w_acc & ~r_prev;
endmodule

// File: rtl/activity_selector.sv
// activity_selector: button front-end, activity FSM and 1-second time base
//   clk       - system clock, all state on rising edge
//   rst_n     - asynchronous active-low reset
//   btn_run / btn_walk / btn_cycle / btn_pause - raw buttons, active-high
//   run / walk / cycle - one-cycle pulse per elapsed second of that activity
//   activity  - current state code (IDLE=0 RUN=1 WALK=2 CYCLE=3 PAUSED=4)
// Build option: ACTIVITY_DEBOUNCE_EN enables button debouncing.
module activity_selector
    import fitness_pkg::*;
#(
    parameter int TICK_DIV        = 100,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_run,
    input  logic             btn_walk,
    input  logic             btn_cycle,
    input  logic             btn_pause,
    output logic             run,
    output logic             walk,
    output logic             cycle,
    output logic [ACT_W-1:0] activity
);
    localparam int PW = $clog2(TICK_DIV);
    logic [3:0]    w_btn;
    logic [3:0]    w_press;
    activity_e     r_state;
    activity_e     r_last;
    activity_e     w_next;
    logic          w_resume;
    logic          w_clear;
    logic          w_wrap;
    logic [PW-1:0] r_presc;
    if (TICK_DIV < 2) begin : g_bad_tick_div
    end
    // Bit order doubles as priority order: run, walk, cycle, pause.
    assign w_btn = {btn_pause, btn_cycle, btn_walk, btn_run};
    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .i_clk  (clk),
            .i_rst_n(rst_n),
            .i_btn  (w_btn[i]),
            .o_press(w_press[i])
        );
    end
    always_comb begin
        w_next   = r_state;
        w_resume = 1'b0;
        if (w_press[0]) begin
            w_next = ACT_RUN;
        end else if (w_press[1]) begin
            w_next = ACT_WALK;
        end else if (w_press[2]) begin
            w_next = ACT_CYCLE;
        end else if (w_press[3] && is_active(r_state)) begin
            w_next = ACT_PAUSED;
        end else if (w_press[3] && r_state == ACT_PAUSED) begin
            w_next   = r_last;
            w_resume = 1'b1;
        end
    end
    // A fresh activity starts a fresh second; a resume keeps the partial one.
    assign w_clear = w_next != r_state && is_active(w_next) && !w_resume;
    assign w_wrap  = r_presc == PW'(TICK_DIV - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACT_IDLE;
            r_last  <= ACT_RUN;
            r_presc <= '0;
            run     <= 1'b0;
            walk    <= 1'b0;
            cycle   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == ACT_PAUSED && r_state != ACT_PAUSED) r_last <= r_state;
            r_presc <= (w_clear || w_next == ACT_IDLE) ? '0 :
                       is_active(r_state) ? (w_wrap ? '0 : r_presc + 1'b1) : r_presc;
            // Pre-edge state decides credit, so a second ending on a switch edge goes to the old activity.
            run     <= r_state == ACT_RUN   && w_wrap;
            walk    <= r_state == ACT_WALK  && w_wrap;
            cycle   <= r_state == ACT_CYCLE && w_wrap;
        end
    end
    assign activity = r_state;
endmodule
